uart_rx_deserializer: RTL

- Receive-side counterpart of the UART transmitter. Consumes the serial line that the transmitter drives.
- Oversamples the line using a tick enable and recovers start, data, parity and stop bits.
- Presents each received character with its per-frame error flags on a one-entry valid/ready output register. The RX FIFO sits downstream of that register.
- Frame format matches the transmitter exactly: idle high, start bit 0, data LSB first (5–9 bits), optional even parity, one or two stop bits.

---
 rtl/uart_rx_deserializer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_deserializer.sv
// UART receiver: oversampled start/data/parity/stop recovery with majority-vote
// bit decisions, feeding a one-entry valid/ready output register.
module uart_rx_deserializer #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_i,
  input  logic       rx_enable_i,
  input  logic       rx_i,
  output logic       rts_n_o,
  input  logic [3:0] frame_len_i,
  input  logic       parity_en_i,
  input  logic       dstop_i,
  input  logic       clear_err_i,
  output logic [8:0] rx_d_o,
  output logic       rx_d_valid_o,
  input  logic       rx_d_ready_i,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int H  = OVERSAMPLE / 2;
  localparam logic [CW-1:0] CNT_LO   = CW'(H - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(H);
  localparam logic [CW-1:0] CNT_HI   = CW'(H + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DSTOP
  } state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rxs;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          sync_reg[gi] <= 1'b1;
        else if (gi == 0)
          sync_reg[gi] <= rx_i;
        else
          sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
      end
    end
  endgenerate

  assign rxs = sync_reg[SYNC_STAGES-1];

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [3:0]    bitcnt_reg;
  logic [3:0]    nbits_reg;
  logic          par_en_reg;
  logic          dstop_reg;
  logic [8:0]    shift_reg;
  logic [1:0]    samp_reg;
  logic          perr_reg;
  logic          ferr_reg;
  logic          done_reg;

  logic          vote;
  logic          decide;
  logic          bit_end;
  logic [3:0]    len_dec;

  assign vote    = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rxs) | (samp_reg[1] & rxs);
  assign decide  = tick_i && (cnt_reg == CNT_HI);
  assign bit_end = tick_i && (cnt_reg == CNT_LAST);

  always_comb begin
    len_dec = 4'd9;
    if (frame_len_i[0])      len_dec = 4'd5;
    else if (frame_len_i[1]) len_dec = 4'd6;
    else if (frame_len_i[2]) len_dec = 4'd7;
    else if (frame_len_i[3]) len_dec = 4'd8;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      bitcnt_reg <= '0;
      nbits_reg  <= 4'd8;
      par_en_reg <= 1'b0;
      dstop_reg  <= 1'b0;
      shift_reg  <= '0;
      samp_reg   <= 2'b11;
      perr_reg   <= 1'b0;
      ferr_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (tick_i && state_reg != S_IDLE) begin
        cnt_reg <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
        if (cnt_reg == CNT_LO)  samp_reg[0] <= rxs;
        if (cnt_reg == CNT_MID) samp_reg[1] <= rxs;
      end
      case (state_reg)
        S_IDLE: begin
          if (rx_enable_i && tick_i && !rxs) begin
            cnt_reg    <= '0;
            state_reg  <= S_START;
            nbits_reg  <= len_dec;
            par_en_reg <= parity_en_i;
            dstop_reg  <= dstop_i;
            shift_reg  <= '0;
            perr_reg   <= 1'b0;
            ferr_reg   <= 1'b0;
          end
        end
        S_START: begin
          if (decide && vote) begin
            state_reg <= S_IDLE;
          end else if (bit_end) begin
            state_reg  <= S_DATA;
            bitcnt_reg <= '0;
          end
        end
        S_DATA: begin
          if (decide) shift_reg[bitcnt_reg] <= vote;
          if (bit_end) begin
            if (bitcnt_reg == nbits_reg - 4'd1)
              state_reg <= par_en_reg ? S_PARITY : S_STOP;
            else
              bitcnt_reg <= bitcnt_reg + 4'd1;
          end
        end
        S_PARITY: begin
          if (decide) perr_reg <= vote ^ (^shift_reg);
          if (bit_end) state_reg <= S_STOP;
        end
        // Leave at the stop-bit decision rather than the bit end, so a
        // back-to-back start edge is seen with half a bit of margin.
        S_STOP: begin
          if (decide) begin
            ferr_reg <= ~vote;
            if (dstop_reg) begin
              state_reg <= S_DSTOP;
            end else begin
              state_reg <= S_IDLE;
              done_reg  <= 1'b1;
            end
          end
        end
        S_DSTOP: begin
          if (decide) begin
            ferr_reg  <= ferr_reg | ~vote;
            done_reg  <= 1'b1;
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  logic [8:0] data_reg;
  logic       valid_reg;
  logic       perr_out_reg;
  logic       ferr_out_reg;
  logic       overrun_reg;
  logic       rts_n_reg;
  logic       blocked;

  assign blocked = valid_reg && !rx_d_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      perr_out_reg <= 1'b0;
      ferr_out_reg <= 1'b0;
      overrun_reg  <= 1'b0;
      rts_n_reg    <= 1'b0;
    end else begin
      if (done_reg && blocked)
        overrun_reg <= 1'b1;
      else if (clear_err_i)
        overrun_reg <= 1'b0;
      if (done_reg && !blocked) begin
        data_reg     <= shift_reg;
        perr_out_reg <= perr_reg;
        ferr_out_reg <= ferr_reg;
        valid_reg    <= 1'b1;
      end else if (valid_reg && rx_d_ready_i) begin
        valid_reg <= 1'b0;
      end
      rts_n_reg <= valid_reg;
    end
  end

  assign rx_d_o       = data_reg;
  assign rx_d_valid_o = valid_reg;
  assign parity_err_o = perr_out_reg;
  assign frame_err_o  = ferr_out_reg;
  assign overrun_o    = overrun_reg;
  assign rts_n_o      = rts_n_reg;

endmodule
